// File: rtl/ram_sdp_same_clock.sv
// ram_sdp_same_clock
//   Simple dual-port storage array with one clock, no reset on the contents.
//   It has one write port. The read port is registered: rd_data takes
//   mem[rd_addr] at an edge where rd_en=1 and holds its value otherwise.
// Ports:
//   clk      clock, positive edge
//   wr_en    write strobe
//   wr_addr  write address
//   wr_data  write data
//   rd_en    read strobe (loads the read register)
//   rd_addr  read address
//   rd_data  registered read data
module ram_sdp_same_clock #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_same_clock_levels.sv
// fifo_same_clock_levels
//   Single-clock first-word-fall-through FIFO. It provides a fill level,
//   full / almost-full / almost-empty decodes, and sticky overflow and
//   underflow flags. The registered read port of the storage RAM doubles as
//   the output register.
// Ports:
//   clk           clock, positive edge
//   rst           synchronous reset, active high
//   we            write request
//   re            read request, acknowledges the current data_out word
//   data_in       write data
//   data_out      head word, valid while nempty=1
//   nempty        data_out holds a valid word
//   full          fill == capacity
//   almost_full   fill >= AFULL_LEVEL
//   almost_empty  fill <= AEMPTY_LEVEL
//   fill          words accepted and not yet read
//   over          sticky: write attempted while full
//   under         sticky: read attempted while nempty=0
//   clr_err       clears over and under
module fifo_same_clock_levels #(
    parameter int DATA_WIDTH   = 16,
    parameter int DATA_DEPTH   = 4,
    parameter int AFULL_LEVEL  = 12,
    parameter int AEMPTY_LEVEL = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  nempty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [DATA_DEPTH:0]   fill,
    output logic                  over,
    output logic                  under,
    input  logic                  clr_err
);

    localparam int                CAP      = 1 << DATA_DEPTH;
    localparam logic [DATA_DEPTH:0] CAP_F    = (DATA_DEPTH+1)'(CAP);
    localparam logic [DATA_DEPTH:0] AFULL_F  = (DATA_DEPTH+1)'(AFULL_LEVEL);
    localparam logic [DATA_DEPTH:0] AEMPTY_F = (DATA_DEPTH+1)'(AEMPTY_LEVEL);
    localparam logic [DATA_DEPTH:0] ONE_F    = (DATA_DEPTH+1)'(1);

    // Pointers carry one extra wrap bit so that wptr != rptr means
    // "RAM holds words not yet fetched into the read register".
    logic [DATA_DEPTH:0] wptr;
    logic [DATA_DEPTH:0] rptr;
    logic                head_vld_p1;   // read register holds an unread word
    logic                wr_acc;
    logic                rd_acc;
    logic                fetch;

    assign full         = (fill == CAP_F);
    assign almost_full  = (fill >= AFULL_F);
    assign almost_empty = (fill <= AEMPTY_F);

    assign wr_acc = we && !full && !rst;
    assign rd_acc = re && nempty && !rst;
    // Fetch whenever the read register is free or is being consumed. Words
    // written at this same edge are not yet visible through wptr, so the read
    // address never collides with the write address.
    assign fetch  = (wptr != rptr) && (!head_vld_p1 || rd_acc) && !rst;

    ram_sdp_same_clock #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (DATA_DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc),
        .wr_addr (wptr[DATA_DEPTH-1:0]),
        .wr_data (data_in),
        .rd_en   (fetch),
        .rd_addr (rptr[DATA_DEPTH-1:0]),
        .rd_data (data_out)
    );

    // p1: read register loaded; presentation: nempty follows one edge later
    // for a word arriving into an idle output. A word replacing a consumed
    // head is presented at once, so streaming has no bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr        <= '0;
            rptr        <= '0;
            fill        <= '0;
            head_vld_p1 <= 1'b0;
            nempty      <= 1'b0;
            over        <= 1'b0;
            under       <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + ONE_F;
            end
            if (fetch) begin
                rptr <= rptr + ONE_F;
            end

            if (wr_acc && !rd_acc) begin
                fill <= fill + ONE_F;
            end else if (rd_acc && !wr_acc) begin
                fill <= fill - ONE_F;
            end

            if (fetch) begin
                head_vld_p1 <= 1'b1;
            end else if (rd_acc) begin
                head_vld_p1 <= 1'b0;
            end

            nempty <= rd_acc ? fetch : head_vld_p1;

            // A new error event wins over a simultaneous clear.
            over  <= (we && full)    || (over  && !clr_err);
            under <= (re && !nempty) || (under && !clr_err);
        end
    end

endmodule

// File: tb/tb_fifo_same_clock_levels.sv
// tb_fifo_same_clock_levels
//   Bench for fifo_same_clock_levels (DATA_WIDTH=8, capacity 4, AFULL_LEVEL=3,
//   AEMPTY_LEVEL=1). It applies a table of vectors with hand-derived
//   expectations, then hand-written corner sequences, then random traffic.
//   Every step is also compared against a queue-based reference model.
module tb_fifo_same_clock_levels;

    logic       clk;
    logic       rst;
    logic       we;
    logic       re;
    logic       clr_err;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       nempty;
    logic       full;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] fill;
    logic       over;
    logic       under;

    fifo_same_clock_levels #(
        .DATA_WIDTH   (8),
        .DATA_DEPTH   (2),
        .AFULL_LEVEL  (3),
        .AEMPTY_LEVEL (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .we           (we),
        .re           (re),
        .data_in      (data_in),
        .data_out     (data_out),
        .nempty       (nempty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .fill         (fill),
        .over         (over),
        .under        (under),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: the stored words in order, plus the edge index after
    // which the current head word becomes visible on data_out.
    logic [7:0] mq[$];
    int         head_vis = 0;
    int         ecnt     = 0;
    bit         m_over   = 1'b0;
    bit         m_under  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", nm, act, exp, ecnt);
        end
    endtask

    task automatic model_edge(input bit r, input bit w, input bit rd, input bit c,
                              input logic [7:0] d);
        bit m_ne;
        bit m_full;
        bit wa;
        bit ra;
        int e;
        e = ecnt + 1;
        if (r) begin
            mq.delete();
            m_over  = 1'b0;
            m_under = 1'b0;
        end else begin
            m_ne   = (mq.size() > 0) && (ecnt >= head_vis);
            m_full = (mq.size() == 4);
            wa = w && !m_full;
            ra = rd && m_ne;
            m_over  = (w && m_full) || (m_over && !c);
            m_under = (rd && !m_ne) || (m_under && !c);
            if (ra) begin
                void'(mq.pop_front());
                // Any remaining word was written earlier and is already in
                // the RAM, so it is presented right after this edge.
                head_vis = e;
            end
            if (wa) begin
                if (mq.size() == 0) head_vis = e + 2;
                mq.push_back(d);
            end
        end
        ecnt = e;
    endtask

    task automatic check_model();
        bit ne;
        ne = (mq.size() > 0) && (ecnt >= head_vis);
        chk("m_fill",   32'(fill),         32'(mq.size()));
        chk("m_nempty", 32'(nempty),       32'(ne));
        if (ne) chk("m_data", 32'(data_out), 32'(mq[0]));
        chk("m_full",   32'(full),         32'(mq.size() == 4));
        chk("m_afull",  32'(almost_full),  32'(mq.size() >= 3));
        chk("m_aempty", 32'(almost_empty), 32'(mq.size() <= 1));
        chk("m_over",   32'(over),         32'(m_over));
        chk("m_under",  32'(under),        32'(m_under));
    endtask

    task automatic step(input bit r, input bit w, input bit rd, input bit c,
                        input logic [7:0] d);
        rst = r; we = w; re = rd; clr_err = c; data_in = d;
        @(posedge clk);
        #1;
        model_edge(r, w, rd, c, d);
        check_model();
    endtask

    typedef struct {
        bit         r, w, rd, c;
        logic [7:0] d;
        int         fill;
        bit         ne;
        logic [7:0] dout;
        bit         full, af, ae, ov, un;
    } vec_t;

    vec_t tbl[$];

    task automatic addv(input bit r, input bit w, input bit rd, input bit c, input logic [7:0] d,
                        input int f, input bit ne, input logic [7:0] dout,
                        input bit fu, input bit af, input bit ae, input bit ov, input bit un);
        vec_t v;
        v.r = r; v.w = w; v.rd = rd; v.c = c; v.d = d;
        v.fill = f; v.ne = ne; v.dout = dout;
        v.full = fu; v.af = af; v.ae = ae; v.ov = ov; v.un = un;
        tbl.push_back(v);
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; re = 1'b0; clr_err = 1'b0; data_in = 8'h00;

        //    r  w  rd c  din    fill ne dout   full af ae ov un
        addv(1, 0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0); // reset state
        addv(0, 1, 0, 0, 8'h11, 1, 0, 8'h00, 0, 0, 1, 0, 0); // write into empty
        addv(0, 0, 0, 0, 8'h00, 1, 0, 8'h00, 0, 0, 1, 0, 0); // still hidden
        addv(0, 0, 0, 0, 8'h00, 1, 1, 8'h11, 0, 0, 1, 0, 0); // visible 2 edges on
        addv(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0); // read last word
        addv(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 1); // read empty -> under
        addv(0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0); // clear
        addv(0, 0, 1, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 1); // event beats clear
        addv(0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        addv(0, 1, 0, 0, 8'hA0, 1, 0, 8'h00, 0, 0, 1, 0, 0);
        addv(0, 1, 0, 0, 8'hA1, 2, 0, 8'h00, 0, 0, 0, 0, 0);
        addv(0, 1, 0, 0, 8'hA2, 3, 1, 8'hA0, 0, 1, 0, 0, 0);
        addv(0, 1, 0, 0, 8'hA3, 4, 1, 8'hA0, 1, 1, 0, 0, 0);
        addv(0, 1, 0, 0, 8'hA4, 4, 1, 8'hA0, 1, 1, 0, 1, 0); // dropped, over
        addv(0, 0, 0, 1, 8'h00, 4, 1, 8'hA0, 1, 1, 0, 0, 0);
        addv(0, 0, 1, 0, 8'h00, 3, 1, 8'hA1, 0, 1, 0, 0, 0);
        addv(0, 0, 1, 0, 8'h00, 2, 1, 8'hA2, 0, 0, 0, 0, 0);
        addv(0, 0, 1, 0, 8'h00, 1, 1, 8'hA3, 0, 0, 1, 0, 0);
        addv(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0);
        addv(0, 0, 1, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 1);
        addv(0, 0, 0, 1, 8'h00, 0, 0, 8'h00, 0, 0, 1, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].w, tbl[i].rd, tbl[i].c, tbl[i].d);
            chk($sformatf("t%0d_fill", i),   32'(fill),         32'(tbl[i].fill));
            chk($sformatf("t%0d_nempty", i), 32'(nempty),       32'(tbl[i].ne));
            if (tbl[i].ne) chk($sformatf("t%0d_data", i), 32'(data_out), 32'(tbl[i].dout));
            chk($sformatf("t%0d_full", i),   32'(full),         32'(tbl[i].full));
            chk($sformatf("t%0d_afull", i),  32'(almost_full),  32'(tbl[i].af));
            chk($sformatf("t%0d_aempty", i), 32'(almost_empty), 32'(tbl[i].ae));
            chk($sformatf("t%0d_over", i),   32'(over),         32'(tbl[i].ov));
            chk($sformatf("t%0d_under", i),  32'(under),        32'(tbl[i].un));
        end

        // Full FIFO with simultaneous write and read.
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 8'hB0 + 8'(i));
        step(0, 0, 0, 0, 8'h00);
        chk("wr_rd_full_pre_data", 32'(data_out), 32'hB0);
        step(0, 1, 1, 0, 8'hB4);
        chk("wr_rd_full_fill", 32'(fill), 32'd3);
        chk("wr_rd_full_over", 32'(over), 32'd1);
        chk("wr_rd_full_data", 32'(data_out), 32'hB1);
        step(0, 0, 0, 1, 8'h00);
        for (int i = 0; i < 3; i++) begin
            chk("wr_rd_full_drain", 32'(data_out), 32'(8'hB1 + 8'(i)));
            step(0, 0, 1, 0, 8'h00);
        end
        chk("wr_rd_full_empty", 32'(fill), 32'd0);

        // Streaming at fill 2 across several pointer wraps.
        step(0, 1, 0, 0, 8'hC0);
        step(0, 1, 0, 0, 8'hC1);
        step(0, 0, 0, 0, 8'h00);
        chk("stream_head0", 32'(data_out), 32'hC0);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 1, 0, 8'hC2 + 8'(k));
            chk("stream_fill",   32'(fill),     32'd2);
            chk("stream_nempty", 32'(nempty),   32'd1);
            chk("stream_data",   32'(data_out), 32'(8'hC1 + 8'(k)));
            chk("stream_flags",  32'({over, under}), 32'd0);
        end
        step(0, 0, 1, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);

        // Reset in mid-operation with a write pending.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 8'hD0 + 8'(i));
        chk("rst_pre_fill", 32'(fill), 32'd3);
        step(1, 1, 1, 0, 8'hDF);
        chk("rst_fill",   32'(fill),   32'd0);
        chk("rst_nempty", 32'(nempty), 32'd0);
        chk("rst_flags",  32'({over, under, full, almost_full, almost_empty}), 32'b00001);
        step(0, 1, 0, 0, 8'h11);
        chk("rst_wr_fill",  32'(fill),   32'd1);
        chk("rst_wr_ne1",   32'(nempty), 32'd0);
        step(0, 0, 0, 0, 8'h00);
        chk("rst_wr_ne2",   32'(nempty), 32'd0);
        step(0, 0, 0, 0, 8'h00);
        chk("rst_wr_ne3",   32'(nempty), 32'd1);
        chk("rst_wr_data",  32'(data_out), 32'h11);

        // Random traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 55,
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 6,
                 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
